// File: rtl/branch_pkg.sv
// Shared widths and the prediction-queue entry layout for the branch resolve unit.
package branch_pkg;

   localparam int unsigned PC_W   = 10;
   localparam int unsigned HIST_W = 3;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [HIST_W-1:0] hist;
      logic              pred;
   } pred_entry_t;

   function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h, input logic b);
      return {h[HIST_W-2:0], b};
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of outstanding predictions; flush drops every entry at once.
module pred_fifo
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  pred_entry_t wr_entry,
   output pred_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   pred_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks queued fetch predictions against execute outcomes, keeps speculative and
// committed global history, and drives the prediction-table update port.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pred_valid,
   input  logic [PC_W-1:0]   pred_pc,
   input  logic              pred_taken,
   output logic              pred_ready,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              res_ready,
   output logic [HIST_W-1:0] ghr,
   output logic              upd_we,
   output logic [PC_W-1:0]   upd_pc,
   output logic [HIST_W-1:0] upd_history,
   output logic              upd_taken,
   output logic              mispredict,
   output logic [15:0]       mispredict_cnt
);

   pred_entry_t       head;
   pred_entry_t       new_entry;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              mis;
   logic [HIST_W-1:0] cghr;
   logic [HIST_W-1:0] cghr_next;

   assign pred_ready = !full;
   assign res_ready  = !empty;
   assign push       = pred_valid && !full;
   assign pop        = res_valid && !empty;
   assign mis        = pop && (res_taken != head.pred);
   assign cghr_next  = hist_shift(cghr, res_taken);
   assign new_entry  = '{pc: pred_pc, hist: ghr, pred: pred_taken};

   // A mispredict flushes the queue; the FIFO gives flush priority, so a same-cycle push is dropped.
   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (mis),
      .wr_entry (new_entry),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr            <= '0;
         cghr           <= '0;
         upd_we         <= 1'b0;
         upd_pc         <= '0;
         upd_history    <= '0;
         upd_taken      <= 1'b0;
         mispredict     <= 1'b0;
         mispredict_cnt <= '0;
      end else begin
         upd_we     <= pop;
         mispredict <= mis;
         if (pop) begin
            cghr        <= cghr_next;
            upd_pc      <= head.pc;
            upd_history <= head.hist;
            upd_taken   <= res_taken;
         end
         if (mis) begin
            ghr <= cghr_next;
            if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 16'd1;
         end else if (push) begin
            ghr <= hist_shift(ghr, pred_taken);
         end
      end
   end

   a_no_res_when_empty : assert property (@(posedge clk) disable iff (!rst_n) !(res_valid && empty));

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue-based reference model.
module tb_branch_resolve_unit;
   import branch_pkg::*;

   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              pred_valid = 1'b0;
   logic [PC_W-1:0]   pred_pc = '0;
   logic              pred_taken = 1'b0;
   logic              pred_ready;
   logic              res_valid = 1'b0;
   logic              res_taken = 1'b0;
   logic              res_ready;
   logic [HIST_W-1:0] ghr;
   logic              upd_we;
   logic [PC_W-1:0]   upd_pc;
   logic [HIST_W-1:0] upd_history;
   logic              upd_taken;
   logic              mispredict;
   logic [15:0]       mispredict_cnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_taken     (pred_taken),
      .pred_ready     (pred_ready),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .res_ready      (res_ready),
      .ghr            (ghr),
      .upd_we         (upd_we),
      .upd_pc         (upd_pc),
      .upd_history    (upd_history),
      .upd_taken      (upd_taken),
      .mispredict     (mispredict),
      .mispredict_cnt (mispredict_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue plus integer histories, updated on each active edge.
   typedef struct {
      int unsigned pc;
      int unsigned hist;
      bit          pred;
   } m_entry_t;

   m_entry_t    mq[$];
   int unsigned m_ghr = 0;
   int unsigned m_cghr = 0;
   int unsigned m_pc = 0;
   int unsigned m_hist = 0;
   int unsigned m_cnt = 0;
   bit          m_we = 0;
   bit          m_mis = 0;
   bit          m_taken = 0;
   localparam int unsigned HMOD = 1 << HIST_W;

   always @(posedge clk or negedge rst_n) begin
      bit       do_push;
      bit       do_pop;
      m_entry_t e;
      if (!rst_n) begin
         mq.delete();
         m_ghr = 0; m_cghr = 0; m_pc = 0; m_hist = 0; m_cnt = 0;
         m_we = 0; m_mis = 0; m_taken = 0;
      end else begin
         do_push = pred_valid && (mq.size() < DEPTH);
         do_pop  = res_valid && (mq.size() > 0);
         m_we = 0;
         m_mis = 0;
         if (do_pop) begin
            e = mq.pop_front();
            m_we = 1;
            m_pc = e.pc;
            m_hist = e.hist;
            m_taken = res_taken;
            m_mis = (res_taken != e.pred);
            m_cghr = (m_cghr * 2 + int'(res_taken)) % HMOD;
         end
         if (m_mis) begin
            mq.delete();
            m_ghr = m_cghr;
            if (m_cnt < 65535) m_cnt++;
         end else if (do_push) begin
            e.pc = pred_pc;
            e.hist = m_ghr;
            e.pred = pred_taken;
            mq.push_back(e);
            m_ghr = (m_ghr * 2 + int'(pred_taken)) % HMOD;
         end
      end
   end

   always @(negedge clk) begin
      chk("ghr", 32'(ghr), m_ghr);
      chk("pred_ready", 32'(pred_ready), 32'(mq.size() < DEPTH));
      chk("res_ready", 32'(res_ready), 32'(mq.size() > 0));
      chk("upd_we", 32'(upd_we), 32'(m_we));
      chk("mispredict", 32'(mispredict), 32'(m_mis));
      chk("upd_pc", 32'(upd_pc), m_pc);
      chk("upd_history", 32'(upd_history), m_hist);
      chk("upd_taken", 32'(upd_taken), 32'(m_taken));
      chk("mispredict_cnt", 32'(mispredict_cnt), m_cnt);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int unsigned pc, input bit t);
      pred_valid = 1'b1; pred_pc = PC_W'(pc); pred_taken = t;
      step();
      pred_valid = 1'b0;
   endtask

   task automatic pop(input bit t);
      res_valid = 1'b1; res_taken = t;
      step();
      res_valid = 1'b0;
   endtask

   task automatic both(input int unsigned pc, input bit pt, input bit rt);
      pred_valid = 1'b1; pred_pc = PC_W'(pc); pred_taken = pt;
      res_valid = 1'b1; res_taken = rt;
      step();
      pred_valid = 1'b0; res_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // 1. reset
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("t1_ghr", 32'(ghr), 0);
      chk("t1_pred_ready", 32'(pred_ready), 1);
      chk("t1_res_ready", 32'(res_ready), 0);
      chk("t1_upd_we", 32'(upd_we), 0);
      chk("t1_cnt", 32'(mispredict_cnt), 0);

      // 2. correct prediction
      push(32'h005, 1'b1);
      chk("t2_ghr", 32'(ghr), 32'b001);
      pop(1'b1);
      chk("t2_upd_we", 32'(upd_we), 1);
      chk("t2_upd_pc", 32'(upd_pc), 32'h005);
      chk("t2_upd_hist", 32'(upd_history), 0);
      chk("t2_upd_taken", 32'(upd_taken), 1);
      chk("t2_mis", 32'(mispredict), 0);
      step();
      chk("t2_we_pulse", 32'(upd_we), 0);
      chk("t2_pc_hold", 32'(upd_pc), 32'h005);

      // 3. mispredict flush
      do_reset();
      push(32'h010, 1'b1);
      push(32'h011, 1'b0);
      push(32'h012, 1'b1);
      chk("t3_ghr_spec", 32'(ghr), 32'b101);
      pop(1'b0);
      chk("t3_mis", 32'(mispredict), 1);
      chk("t3_upd_taken", 32'(upd_taken), 0);
      chk("t3_upd_hist", 32'(upd_history), 0);
      chk("t3_upd_pc", 32'(upd_pc), 32'h010);
      chk("t3_ghr", 32'(ghr), 0);
      chk("t3_res_ready", 32'(res_ready), 0);
      chk("t3_cnt", 32'(mispredict_cnt), 1);

      // 4. full, ignored push, drain, pointer wrap
      for (int i = 0; i < 4; i++) push(32'h100 + i, (i % 2) == 0);
      chk("t4_full", 32'(pred_ready), 0);
      chk("t4_ghr", 32'(ghr), 32'b010);
      push(32'h3FF, 1'b1);
      chk("t4_ign_ghr", 32'(ghr), 32'b010);
      chk("t4_ign_full", 32'(pred_ready), 0);
      for (int i = 0; i < 4; i++) begin
         pop((i % 2) == 0);
         chk("t4_drain_pc", 32'(upd_pc), 32'h100 + i);
         chk("t4_drain_mis", 32'(mispredict), 0);
      end
      chk("t4_empty", 32'(res_ready), 0);
      push(32'h200, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         both(32'h200 + i, (i % 2) == 1, ((i - 1) % 2) == 1);
         chk("t4_wrap_pc", 32'(upd_pc), 32'h200 + i - 1);
         chk("t4_wrap_mis", 32'(mispredict), 0);
      end
      pop(1'b0);
      chk("t4_last_pc", 32'(upd_pc), 32'h208);
      chk("t4_cnt", 32'(mispredict_cnt), 1);

      // 5. push dropped by a same-cycle mispredicting pop
      do_reset();
      push(32'h030, 1'b1);
      both(32'h020, 1'b1, 1'b0);
      chk("t5_mis", 32'(mispredict), 1);
      chk("t5_upd_pc", 32'(upd_pc), 32'h030);
      chk("t5_res_ready", 32'(res_ready), 0);
      chk("t5_ghr", 32'(ghr), 0);
      chk("t5_cnt", 32'(mispredict_cnt), 1);
      step();
      chk("t5_still_empty", 32'(res_ready), 0);

      // 6. async reset with entries in flight
      push(32'h040, 1'b1);
      push(32'h041, 1'b0);
      push(32'h042, 1'b1);
      pop(1'b1);
      chk("t6_pre_pc", 32'(upd_pc), 32'h040);
      chk("t6_pre_ghr", 32'(ghr), 32'b101);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_ghr", 32'(ghr), 0);
      chk("t6_upd_pc", 32'(upd_pc), 0);
      chk("t6_upd_we", 32'(upd_we), 0);
      chk("t6_cnt", 32'(mispredict_cnt), 0);
      chk("t6_res_ready", 32'(res_ready), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) step();
      chk("t6_no_upd", 32'(upd_we), 0);
      chk("t6_post_res_ready", 32'(res_ready), 0);
      chk("t6_post_pred_ready", 32'(pred_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
